id_ex_operand_stage: RTL and testbench

//  Decode/execute boundary stage feeding the ALU: decodes opcode/funct to the 4-bit ALU control code.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_ctrl_decode.sv | 63 ++++++
 rtl/id_ex_operand_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcode/funct constants and datapath widths
// for the decode/execute boundary.
package alu_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_ADDU = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b1111;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b0010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode to ALU control plus operand
// and destination selects.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       imm_sel,
  output logic       ext_sign,
  output logic       rd_sel,
  output logic       regwrite,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_NOP;
    imm_sel  = 1'b0;
    ext_sign = 1'b0;
    rd_sel   = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        rd_sel = 1'b1;
        unique case (funct)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_ADDU:  alu_ctrl = ALU_ADDU;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_SLT:   alu_ctrl = ALU_SLT;
          F_SLL:   alu_ctrl = ALU_SLL;
          F_SRL:   alu_ctrl = ALU_SRL;
          F_SRA:   alu_ctrl = ALU_SRA;
          default: alu_ctrl = ALU_NOP;
        endcase
      end
      (opcode == OP_ADDI): begin
        alu_ctrl = ALU_ADD;
        imm_sel  = 1'b1;
        ext_sign = 1'b1;
      end
      (opcode == OP_ADDIU): begin
        alu_ctrl = ALU_ADDU;
        imm_sel  = 1'b1;
        ext_sign = 1'b1;
      end
      (opcode == OP_ANDI): begin
        alu_ctrl = ALU_AND;
        imm_sel  = 1'b1;
      end
      (opcode == OP_ORI): begin
        alu_ctrl = ALU_OR;
        imm_sel  = 1'b1;
      end
      default: alu_ctrl = ALU_NOP;
    endcase
  end

  // No legal instruction maps to 0000, so it doubles as the trap marker
  assign illegal  = (alu_ctrl == ALU_NOP);
  assign regwrite = !illegal;

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: decode, forward, select and register ALU operands.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [15:0]   imm,
  input  logic          exmem_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_wr,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    ALUcontrol,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [RW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          illegal
);

  import alu_pkg::*;

  logic [3:0]    dec_alu;
  logic          imm_sel;
  logic          ext_sign;
  logic          rd_sel;
  logic          dec_rw;
  logic          dec_ill;
  logic [DW-1:0] rs_op;
  logic [DW-1:0] rt_op;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] nxt_a;
  logic [DW-1:0] nxt_b;
  logic [RW-1:0] nxt_rd;
  logic          nxt_rw;
  logic          load;

  alu_ctrl_decode u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (dec_alu),
    .imm_sel  (imm_sel),
    .ext_sign (ext_sign),
    .rd_sel   (rd_sel),
    .regwrite (dec_rw),
    .illegal  (dec_ill)
  );

`ifdef ID_EX_FWD_EN
  // Younger EX/MEM result wins; r0 is never forwarded
  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] addr,
    input logic [DW-1:0] rf
  );
    if (exmem_wr && exmem_rd == addr && addr != '0)
      return exmem_data;
    else if (memwb_wr && memwb_rd == addr && addr != '0)
      return memwb_data;
    else
      return rf;
  endfunction

  assign rs_op = fwd(rs_addr, rs_data);
  assign rt_op = fwd(rt_addr, rt_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_wr, exmem_rd, exmem_data,
                        memwb_wr, memwb_rd, memwb_data,
                        rs_addr};
  assign rs_op = rs_data;
  assign rt_op = rt_data;
`endif

  assign imm_ext = ext_sign ? {{(DW-16){imm[15]}}, imm}
                            : {{(DW-16){1'b0}}, imm};

  assign nxt_a  = dec_ill ? '0 : rs_op;
  assign nxt_b  = dec_ill ? '0 : (imm_sel ? imm_ext : rt_op);
  assign nxt_rd = rd_sel ? rd_addr : rt_addr;
  assign nxt_rw = dec_rw && (nxt_rd != '0);

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      ALUcontrol  <= ALU_NOP;
      A           <= '0;
      B           <= '0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      ex_regwrite <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      ALUcontrol  <= dec_alu;
      A           <= nxt_a;
      B           <= nxt_b;
      ex_rd       <= nxt_rd;
      ex_regwrite <= nxt_rw;
      illegal     <= dec_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: table-driven reference model with a
// per-cycle compare, plus directed literal checks.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        exmem_wr;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        memwb_wr;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUcontrol;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .opcode(opcode), .funct(funct),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUcontrol(ALUcontrol), .A(A), .B(B),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .illegal(illegal)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value the instruction should see for a source register
  function automatic logic [31:0] src_val(input logic [4:0] addr,
                                          input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
    if (exmem_wr && exmem_rd == addr && addr != 0) return exmem_data;
    if (memwb_wr && memwb_rd == addr && addr != 0) return memwb_data;
`endif
    return rf;
  endfunction

  // Reference: mnemonic table -> operation result bundle
  task automatic ref_op(output logic [3:0] alu, output logic [31:0] a,
                        output logic [31:0] b, output logic [4:0] dst,
                        output logic rw, output logic ill);
    int kind; // 0 reg, 1 sign-ext imm, 2 zero-ext imm
    alu = 0; kind = 0; ill = 0;
    if (opcode == 0) begin
      case (funct)
        6'h20: alu = 4'b1000;
        6'h21: alu = 4'b0110;
        6'h22: alu = 4'b1001;
        6'h24: alu = 4'b1100;
        6'h25: alu = 4'b0100;
        6'h2a: alu = 4'b1111;
        6'h00: alu = 4'b1011;
        6'h02: alu = 4'b1010;
        6'h03: alu = 4'b0010;
        default: ill = 1;
      endcase
    end else if (opcode == 6'h08) begin alu = 4'b1000; kind = 1; end
    else if (opcode == 6'h09) begin alu = 4'b0110; kind = 1; end
    else if (opcode == 6'h0c) begin alu = 4'b1100; kind = 2; end
    else if (opcode == 6'h0d) begin alu = 4'b0100; kind = 2; end
    else ill = 1;
    dst = (opcode == 0) ? rd_addr : rt_addr;
    if (ill) begin
      a = 0; b = 0; rw = 0;
    end else begin
      a = src_val(rs_addr, rs_data);
      if (kind == 1) b = {{16{imm[15]}}, imm};
      else if (kind == 2) b = {16'h0, imm};
      else b = src_val(rt_addr, rt_data);
      rw = (dst != 0);
    end
  endtask

  logic        m_valid, m_data_known, m_rw_known, m_ill, m_rw;
  logic [3:0]  m_alu;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;

  always @(posedge clk) begin
    logic [3:0] t_alu; logic [31:0] t_a, t_b;
    logic [4:0] t_rd; logic t_rw, t_ill;
    ref_op(t_alu, t_a, t_b, t_rd, t_rw, t_ill);
    if (reset) begin
      m_valid <= 0; m_alu <= 0; m_a <= 0; m_b <= 0; m_rd <= 0;
      m_rw <= 0; m_ill <= 0; m_data_known <= 1; m_rw_known <= 1;
    end else if (flush) begin
      m_valid <= 0; m_rw <= 0; m_rw_known <= 1; m_data_known <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1; m_alu <= t_alu; m_a <= t_a; m_b <= t_b;
      m_rd <= t_rd; m_rw <= t_rw; m_ill <= t_ill;
      m_data_known <= 1; m_rw_known <= 1;
    end else if (out_ready && m_valid) begin
      m_valid <= 0; m_data_known <= 0; m_rw_known <= 0;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) if (cmp_en) begin
    chk("m.out_valid", out_valid, m_valid);
    chk("m.in_ready", in_ready, !m_valid || out_ready);
    if (m_rw_known) chk("m.ex_regwrite", ex_regwrite, m_rw);
    if (m_data_known) begin
      chk("m.ALUcontrol", ALUcontrol, m_alu);
      chk("m.A", A, m_a);
      chk("m.B", B, m_b);
      chk("m.illegal", illegal, m_ill);
      if (!m_ill) chk("m.ex_rd", ex_rd, m_rd);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_ins(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [15:0] im);
    opcode = op; funct = fn; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; imm = im;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [15:0] im);
    set_ins(op, fn, rs, rt, rd, rsd, rtd, im);
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  logic [5:0] rfn [9] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25,
                          6'h2a, 6'h00, 6'h02, 6'h03};
  logic [5:0] iop [4] = '{6'h08, 6'h09, 6'h0c, 6'h0d};

  initial begin
    reset = 1; in_valid = 0; flush = 0; out_ready = 1;
    exmem_wr = 0; exmem_rd = 0; exmem_data = 0;
    memwb_wr = 0; memwb_rd = 0; memwb_data = 0;
    set_ins(6'h00, 6'h20, 5, 6, 1, 32'h5, 32'h6, 16'h0);
    in_valid = 1;
    #2;
    cmp_en = 1;
    tick();
    chk("rst.out_valid", out_valid, 0);
    tick();
    chk("rst.out_valid2", out_valid, 0);
    chk("rst.ALUcontrol", ALUcontrol, 0);
    chk("rst.A", A, 0);
    chk("rst.ex_regwrite", ex_regwrite, 0);
    reset = 0;
    tick();
    in_valid = 0;
    chk("add.out_valid", out_valid, 1);
    chk("add.ALUcontrol", ALUcontrol, 4'b1000);

    issue(6'h00, 6'h22, 1, 2, 7, 32'd10, 32'd3, 16'h0);
    chk("sub.A", A, 32'd10);
    chk("sub.B", B, 32'd3);
    chk("sub.ALUcontrol", ALUcontrol, 4'b1001);
    chk("sub.ex_rd", ex_rd, 7);
    chk("sub.ex_regwrite", ex_regwrite, 1);

    issue(6'h08, 6'h00, 1, 8, 0, 32'h100, 32'h0, 16'hFFFE);
    chk("addi.B", B, 32'hFFFFFFFE);
    chk("addi.ALUcontrol", ALUcontrol, 4'b1000);
    chk("addi.ex_rd", ex_rd, 8);
    issue(6'h0c, 6'h00, 1, 9, 0, 32'h100, 32'h0, 16'hFFFE);
    chk("andi.B", B, 32'h0000FFFE);
    chk("andi.ALUcontrol", ALUcontrol, 4'b1100);

    // Backpressure: hold three cycles with a new instruction waiting
    issue(6'h00, 6'h20, 1, 2, 3, 32'h11, 32'h22, 16'h0);
    out_ready = 0;
    set_ins(6'h00, 6'h25, 1, 2, 4, 32'h33, 32'h44, 16'h0);
    in_valid = 1;
    #1;
    chk("stall.in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.out_valid", out_valid, 1);
      chk("stall.A", A, 32'h11);
      chk("stall.ALUcontrol", ALUcontrol, 4'b1000);
      chk("stall.in_ready", in_ready, 0);
    end
    out_ready = 1;
    #1;
    chk("release.in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("release.ALUcontrol", ALUcontrol, 4'b0100);
    chk("release.A", A, 32'h33);

    // Flush against a held instruction and a simultaneous load
    out_ready = 0;
    set_ins(6'h00, 6'h24, 1, 2, 5, 32'h1, 32'h2, 16'h0);
    in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0; out_ready = 1;
    chk("flush.out_valid", out_valid, 0);
    chk("flush.ex_regwrite", ex_regwrite, 0);

    exmem_wr = 1; exmem_rd = 4; exmem_data = 32'hAA;
    memwb_wr = 1; memwb_rd = 4; memwb_data = 32'hBB;
    issue(6'h00, 6'h20, 4, 2, 3, 32'h1234, 32'h9, 16'h0);
`ifdef ID_EX_FWD_EN
    chk("fwd.A", A, 32'hAA);
`else
    chk("fwd.A", A, 32'h1234);
`endif
    exmem_rd = 0; memwb_rd = 0;
    issue(6'h00, 6'h20, 0, 2, 3, 32'h55, 32'h9, 16'h0);
    chk("fwd0.A", A, 32'h55);
    exmem_wr = 0; memwb_wr = 0;

    issue(6'h3f, 6'h20, 1, 2, 3, 32'h77, 32'h88, 16'h1);
    chk("ill.illegal", illegal, 1);
    chk("ill.ALUcontrol", ALUcontrol, 0);
    chk("ill.ex_regwrite", ex_regwrite, 0);
    chk("ill.A", A, 0);

    issue(6'h00, 6'h20, 1, 2, 0, 32'h1, 32'h2, 16'h0);
    chk("rd0.ex_regwrite", ex_regwrite, 0);
    issue(6'h00, 6'h00, 1, 2, 6, 32'h1, 32'h2, 16'h0);
    chk("sll.ALUcontrol", ALUcontrol, 4'b1011);

    foreach (rfn[i])
      issue(6'h00, rfn[i], 5'(i + 1), 5'(i + 2), 5'(i % 3),
            32'h1000 + i, 32'h2000 + i, 16'h0);
    foreach (iop[i])
      issue(iop[i], 6'h15, 5'(i + 3), 5'(i), 5'd2,
            32'hC0 + i, 32'hD0, 16'h8001 + 16'(i));
    issue(6'h00, 6'h3f, 1, 2, 3, 32'h1, 32'h2, 16'h0);

    // Back-to-back stream with intermittent backpressure
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      set_ins(6'h00, rfn[i], 5'(i), 5'(i + 1), 5'(i + 9),
              32'h300 + i, 32'h400 + i, 16'h0);
      out_ready = (i % 3) != 1;
      tick();
    end
    in_valid = 0; out_ready = 1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
